// File: rtl/spi_mem_pkg.sv
// Shared FSM state encoding and SPI SRAM opcodes.
// Defining SPI_MEM_FAST_READ_EN adds the DUMMY state and switches reads to 0x0B.
package spi_mem_pkg;

   localparam logic [7:0] CMD_WRITE     = 8'h02;
   localparam logic [7:0] CMD_READ      = 8'h03;
   localparam logic [7:0] CMD_FAST_READ = 8'h0B;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
`ifdef SPI_MEM_FAST_READ_EN
      ST_DUMMY,
`endif
      ST_WDATA,
      ST_RDATA,
      ST_DONE
   } state_t;

   function automatic logic [7:0] read_cmd();
`ifdef SPI_MEM_FAST_READ_EN
      return CMD_FAST_READ;
`else
      return CMD_READ;
`endif
   endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: CLK_DIV clk cycles per half-period, idles low while disabled.
// The strobes flag the clk edge at which sclk will rise or fall.
module spi_sclk_gen #(
   parameter int CLK_DIV = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic i_en,
   output logic o_sclk,
   output logic o_rise_stb,
   output logic o_fall_stb
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] r_cnt;
   logic          r_sclk;
   logic          w_tick;

   assign w_tick     = i_en && (r_cnt == CW'(CLK_DIV - 1));
   assign o_rise_stb = w_tick && !r_sclk;
   assign o_fall_stb = w_tick && r_sclk;
   assign o_sclk     = r_sclk;

   always_ff @(posedge clk) begin
      if (reset || !i_en) begin
         r_cnt  <= '0;
         r_sclk <= 1'b0;
      end else if (w_tick) begin
         r_cnt  <= '0;
         r_sclk <= ~r_sclk;
      end else begin
         r_cnt  <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/spi_burst_mem_controller.sv
// Burst memory port to SPI SRAM bridge (mode 0, MSB first, single CS window per burst).
// Define SPI_MEM_FAST_READ_EN for 0x0B reads with 8 dummy clocks.
module spi_burst_mem_controller
   import spi_mem_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int LEN_W   = 4,
   parameter int CLK_DIV = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [LEN_W-1:0]  mem_len,
   input  logic [7:0]        mem_wdata,
   output logic              wr_pop,
   output logic [7:0]        mem_rdata,
   output logic              rd_valid,
   output logic              mem_ready,
   output logic              busy,
   output logic              spi_cs_n,
   output logic              spi_sclk,
   output logic              spi_mosi,
   input  logic              spi_miso
);

   localparam logic [1:0] ABYTES_M1 = 2'(ADDR_W / 8 - 1);

   state_t             r_state;
   logic               r_we;
   logic [ADDR_W-1:0]  r_addr;
   logic [LEN_W-1:0]   r_len;
   logic [LEN_W-1:0]   r_bytecnt;
   logic [1:0]         r_abytes;
   logic [7:0]         r_wdata0;
   logic [7:0]         r_sh;
   logic [6:0]         r_rx;
   logic [2:0]         r_bitcnt;
   logic               r_run;
   logic               r_cs_n;
   logic [7:0]         r_rdata;
   logic               r_rd_valid;
   logic               r_mem_ready;
   logic               r_busy;

   logic               w_rise;
   logic               w_fall;
   logic               w_byte_end;

   spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
      .clk        (clk),
      .reset      (reset),
      .i_en       (r_run),
      .o_sclk     (spi_sclk),
      .o_rise_stb (w_rise),
      .o_fall_stb (w_fall)
   );

   // bit counter wraps to 0 after the 8th rise, so this is the fall closing a byte
   assign w_byte_end = w_fall && (r_bitcnt == 3'd0);

   // show-ahead source: mem_wdata is taken at the same edge that ends the byte
   assign wr_pop    = w_byte_end && (r_state == ST_WDATA) && (r_bytecnt != '0);
   assign spi_mosi  = r_sh[7];
   assign spi_cs_n  = r_cs_n;
   assign mem_rdata = r_rdata;
   assign rd_valid  = r_rd_valid;
   assign mem_ready = r_mem_ready;
   assign busy      = r_busy;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_len       <= '0;
         r_bytecnt   <= '0;
         r_abytes    <= '0;
         r_wdata0    <= '0;
         r_sh        <= '0;
         r_rx        <= '0;
         r_bitcnt    <= '0;
         r_run       <= 1'b0;
         r_cs_n      <= 1'b1;
         r_rdata     <= '0;
         r_rd_valid  <= 1'b0;
         r_mem_ready <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_rd_valid  <= 1'b0;
         r_mem_ready <= 1'b0;

         if (w_rise) begin
            r_rx     <= {r_rx[5:0], spi_miso};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_state == ST_RDATA && r_bitcnt == 3'd7) begin
               r_rdata    <= {r_rx, spi_miso};
               r_rd_valid <= 1'b1;
            end
         end

         if (w_fall && !w_byte_end)
            r_sh <= {r_sh[6:0], 1'b0};

         case (r_state)
            ST_IDLE: begin
               r_busy <= 1'b0;
               if (mem_req) begin
                  r_we     <= mem_we;
                  r_addr   <= mem_addr;
                  r_len    <= mem_len;
                  r_wdata0 <= mem_wdata;
                  r_sh     <= mem_we ? CMD_WRITE : read_cmd();
                  r_bitcnt <= '0;
                  r_run    <= 1'b1;
                  r_cs_n   <= 1'b0;
                  r_busy   <= 1'b1;
                  r_state  <= ST_CMD;
               end
            end

            ST_CMD: begin
               if (w_byte_end) begin
                  r_sh     <= r_addr[ADDR_W-1 -: 8];
                  r_addr   <= r_addr << 8;
                  r_abytes <= ABYTES_M1;
                  r_state  <= ST_ADDR;
               end
            end

            ST_ADDR: begin
               if (w_byte_end) begin
                  if (r_abytes != 2'd0) begin
                     r_sh     <= r_addr[ADDR_W-1 -: 8];
                     r_addr   <= r_addr << 8;
                     r_abytes <= r_abytes - 2'd1;
                  end else begin
                     r_bytecnt <= r_len;
                     if (r_we) begin
                        r_sh    <= r_wdata0;
                        r_state <= ST_WDATA;
                     end else begin
                        r_sh    <= '0;
`ifdef SPI_MEM_FAST_READ_EN
                        r_state <= ST_DUMMY;
`else
                        r_state <= ST_RDATA;
`endif
                     end
                  end
               end
            end

`ifdef SPI_MEM_FAST_READ_EN
            ST_DUMMY: begin
               if (w_byte_end) begin
                  r_sh    <= '0;
                  r_state <= ST_RDATA;
               end
            end
`endif

            ST_WDATA: begin
               if (w_byte_end) begin
                  if (r_bytecnt != '0) begin
                     r_sh      <= mem_wdata;
                     r_bytecnt <= r_bytecnt - LEN_W'(1);
                  end else begin
                     r_sh        <= '0;
                     r_run       <= 1'b0;
                     r_cs_n      <= 1'b1;
                     r_mem_ready <= 1'b1;
                     r_state     <= ST_DONE;
                  end
               end
            end

            ST_RDATA: begin
               if (w_byte_end) begin
                  if (r_bytecnt != '0) begin
                     r_bytecnt <= r_bytecnt - LEN_W'(1);
                  end else begin
                     r_sh        <= '0;
                     r_run       <= 1'b0;
                     r_cs_n      <= 1'b1;
                     r_mem_ready <= 1'b1;
                     r_state     <= ST_DONE;
                  end
               end
            end

            // mem_ready cycle; busy drops and IDLE may accept from the next cycle on
            ST_DONE: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_burst_mem_controller.sv
// Directed bench: two controllers (16-bit/div1 and 24-bit/div2) sharing one SPI SRAM model.
module tb_spi_burst_mem_controller;

`ifdef SPI_MEM_FAST_READ_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif
   localparam logic [7:0] RDCMD = FAST ? 8'h0B : 8'h03;

   logic clk = 1'b0, reset = 1'b1, req16 = 1'b0, req24 = 1'b0, mem_we = 1'b0;
   logic [23:0] addr = '0;
   logic [3:0]  len = '0;
   logic [7:0]  wdata = '0;
   logic        miso = 1'b0;
   logic        sel = 1'b0;

   logic       pop16, rdv16, rdy16, busy16, cs16, sclk16, mosi16;
   logic       pop24, rdv24, rdy24, busy24, cs24, sclk24, mosi24;
   logic [7:0] rdata16, rdata24;
   logic       w_pop, w_rdv, w_rdy, w_busy, w_cs, w_sclk, w_mosi;
   logic [7:0] w_rdata;

   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   spi_burst_mem_controller #(.ADDR_W(16), .LEN_W(4), .CLK_DIV(1)) dut16 (
      .clk(clk), .reset(reset), .mem_req(req16), .mem_we(mem_we), .mem_addr(addr[15:0]),
      .mem_len(len), .mem_wdata(wdata), .wr_pop(pop16), .mem_rdata(rdata16),
      .rd_valid(rdv16), .mem_ready(rdy16), .busy(busy16), .spi_cs_n(cs16),
      .spi_sclk(sclk16), .spi_mosi(mosi16), .spi_miso(miso));

   spi_burst_mem_controller #(.ADDR_W(24), .LEN_W(4), .CLK_DIV(2)) dut24 (
      .clk(clk), .reset(reset), .mem_req(req24), .mem_we(mem_we), .mem_addr(addr),
      .mem_len(len), .mem_wdata(wdata), .wr_pop(pop24), .mem_rdata(rdata24),
      .rd_valid(rdv24), .mem_ready(rdy24), .busy(busy24), .spi_cs_n(cs24),
      .spi_sclk(sclk24), .spi_mosi(mosi24), .spi_miso(miso));

   assign w_pop   = sel ? pop24   : pop16;
   assign w_rdv   = sel ? rdv24   : rdv16;
   assign w_rdy   = sel ? rdy24   : rdy16;
   assign w_busy  = sel ? busy24  : busy16;
   assign w_cs    = sel ? cs24    : cs16;
   assign w_sclk  = sel ? sclk24  : sclk16;
   assign w_mosi  = sel ? mosi24  : mosi16;
   assign w_rdata = sel ? rdata24 : rdata16;

   // SRAM model contents: 0x1234 -> A5, 0x0010 -> 93, 0x0011 -> 92
   function automatic logic [7:0] model(input logic [23:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h83;
   endfunction

   int          rcnt = 0;
   logic [7:0]  msh = '0;
   logic [31:0] ash = '0;
   logic [23:0] saddr = '0;
   logic [7:0]  mosi_q[$];

   always @(posedge w_sclk or posedge w_cs) begin
      if (w_cs) begin
         rcnt = 0;
      end else begin
         msh  = {msh[6:0], w_mosi};
         ash  = {ash[30:0], w_mosi};
         rcnt = rcnt + 1;
         if (rcnt % 8 == 0) mosi_q.push_back(msh);
         if (rcnt == 8 * (1 + (sel ? 3 : 2)))
            saddr = sel ? ash[23:0] : {8'h00, ash[15:0]};
      end
   end

   always @(negedge w_sclk) begin
      int ds, n;
      logic [7:0] b;
      if (!w_cs) begin
         ds = 8 * (1 + (sel ? 3 : 2)) + (FAST ? 8 : 0);
         if (rcnt >= ds) begin
            n    = rcnt - ds;
            b    = model(saddr + 24'(n / 8));
            miso = b[7 - (n % 8)];
         end else begin
            miso = 1'b0;
         end
      end
   end

   logic [7:0] rd_q[$];
   logic [7:0] wb[5];
   int pops, csl, sclk_hi, rdv_cyc, rdy_cyc, qbase, bad;
   logic done;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic start(input logic s, input logic we, input logic [23:0] a,
                        input logic [3:0] l, input bit hold);
      qbase  = mosi_q.size();
      sel    = s;
      mem_we = we;
      addr   = a;
      len    = l;
      wdata  = wb[0];
      if (s) req24 = 1'b1; else req16 = 1'b1;
      @(posedge clk); #1;
      wdata = wb[1];
      if (!hold) begin req16 = 1'b0; req24 = 1'b0; end
   endtask

   task automatic run_txn(input int maxc);
      logic pend;
      rd_q.delete();
      pops = 0; csl = 0; sclk_hi = 0; rdv_cyc = -1; rdy_cyc = -1; done = 1'b0; pend = 1'b0;
      for (int c = 0; c < maxc && !done; c++) begin
         @(negedge clk);
         if (!w_cs)  csl++;
         if (w_sclk) sclk_hi++;
         if (w_pop) begin pops++; pend = 1'b1; end
         if (w_rdv) begin rd_q.push_back(w_rdata); rdv_cyc = c; end
         if (w_rdy) begin rdy_cyc = c; done = 1'b1; end
         @(posedge clk); #1;
         if (pend) begin wdata = wb[(pops < 4) ? pops + 1 : 4]; pend = 1'b0; end
      end
      chk("ready_seen", 32'(done), 32'd1);
   endtask

   initial begin
      wb = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cs16", 32'(cs16), 32'd1);
      chk("rst_sclk16", 32'(sclk16), 32'd0);
      chk("rst_mosi16", 32'(mosi16), 32'd0);
      chk("rst_rdata16", 32'(rdata16), 32'h00);
      chk("rst_strobes16", {28'd0, pop16, rdv16, rdy16, busy16}, 32'd0);
      chk("rst_cs24", 32'(cs24), 32'd1);
      chk("rst_busy24", 32'(busy24), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // 16-bit read, len 0, CLK_DIV 1
      start(1'b0, 1'b0, 24'h001234, 4'd0, 1'b0);
      run_txn(300);
      chk("r16_cmd", 32'(mosi_q[qbase]), 32'(RDCMD));
      chk("r16_a1", 32'(mosi_q[qbase+1]), 32'h12);
      chk("r16_a0", 32'(mosi_q[qbase+2]), 32'h34);
      chk("r16_nrd", rd_q.size(), 32'd1);
      chk("r16_rd0", 32'(rd_q[0]), 32'hA5);
      chk("r16_rdy_lat", rdy_cyc - rdv_cyc, 32'd1);
      chk("r16_halfper", csl, FAST ? 32'd80 : 32'd64);
      @(negedge clk);
      chk("r16_idle_busy", 32'(w_busy), 32'd0);

      // 24-bit write, len 3, CLK_DIV 2
      wb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
      @(posedge clk); #1;
      start(1'b1, 1'b1, 24'h012345, 4'd3, 1'b0);
      run_txn(600);
      chk("w24_cmd", 32'(mosi_q[qbase]), 32'h02);
      chk("w24_a2", 32'(mosi_q[qbase+1]), 32'h01);
      chk("w24_a1", 32'(mosi_q[qbase+2]), 32'h23);
      chk("w24_a0", 32'(mosi_q[qbase+3]), 32'h45);
      chk("w24_d0", 32'(mosi_q[qbase+4]), 32'h11);
      chk("w24_d1", 32'(mosi_q[qbase+5]), 32'h22);
      chk("w24_d2", 32'(mosi_q[qbase+6]), 32'h33);
      chk("w24_d3", 32'(mosi_q[qbase+7]), 32'h44);
      chk("w24_pops", pops, 32'd3);
      chk("w24_sclk_hi", sclk_hi, 32'd128);
      chk("w24_cs_low", csl, 32'd256);
      chk("w24_nrd", rd_q.size(), 32'd0);

      // 16-bit single-byte write: no wr_pop
      wb = '{8'h5C, 8'hEE, 8'hEE, 8'hEE, 8'hEE};
      @(posedge clk); #1;
      start(1'b0, 1'b1, 24'h00BEEF, 4'd0, 1'b0);
      run_txn(300);
      chk("w16_a1", 32'(mosi_q[qbase+1]), 32'hBE);
      chk("w16_a0", 32'(mosi_q[qbase+2]), 32'hEF);
      chk("w16_d0", 32'(mosi_q[qbase+3]), 32'h5C);
      chk("w16_pops", pops, 32'd0);

      // two-byte read at 0x0010 (dummy byte on MOSI is 00 either way)
      @(posedge clk); #1;
      start(1'b0, 1'b0, 24'h000010, 4'd1, 1'b0);
      run_txn(300);
      chk("r2_cmd", 32'(mosi_q[qbase]), 32'(RDCMD));
      chk("r2_a1", 32'(mosi_q[qbase+1]), 32'h00);
      chk("r2_a0", 32'(mosi_q[qbase+2]), 32'h10);
      chk("r2_b3", 32'(mosi_q[qbase+3]), 32'h00);
      chk("r2_nrd", rd_q.size(), 32'd2);
      chk("r2_rd0", 32'(rd_q[0]), 32'h93);
      chk("r2_rd1", 32'(rd_q[1]), 32'h92);
      chk("r2_halfper", csl, FAST ? 32'd96 : 32'd80);

      // request held high through a burst
      @(posedge clk); #1;
      start(1'b0, 1'b0, 24'h001234, 4'd0, 1'b1);
      run_txn(300);
      chk("hold_bytes", mosi_q.size() - qbase, FAST ? 32'd5 : 32'd4);
      @(negedge clk);
      chk("hold_idle_busy", 32'(w_busy), 32'd0);
      chk("hold_idle_cs", 32'(w_cs), 32'd1);
      @(posedge clk); #1;
      req16 = 1'b0;
      qbase = mosi_q.size();
      @(negedge clk);
      chk("hold_acc_busy", 32'(w_busy), 32'd1);
      chk("hold_acc_cs", 32'(w_cs), 32'd0);
      run_txn(300);
      chk("hold_cmd2", 32'(mosi_q[qbase]), 32'(RDCMD));
      chk("hold_rd2", 32'(rd_q[0]), 32'hA5);

      // reset during the second address byte
      @(posedge clk); #1;
      start(1'b0, 1'b0, 24'h001234, 4'd0, 1'b0);
      for (int i = 0; i < 200 && rcnt < 18; i++) @(negedge clk);
      chk("abort_reached", 32'(rcnt >= 18 && rcnt < 24), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("abort_cs", 32'(cs16), 32'd1);
      chk("abort_sclk", 32'(sclk16), 32'd0);
      chk("abort_busy", 32'(busy16), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      bad = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (rdy16 || rdv16) bad++;
      end
      chk("abort_no_ready", bad, 32'd0);
      @(posedge clk); #1;
      start(1'b0, 1'b0, 24'h001234, 4'd0, 1'b0);
      run_txn(300);
      chk("post_cmd", 32'(mosi_q[qbase]), 32'(RDCMD));
      chk("post_a1", 32'(mosi_q[qbase+1]), 32'h12);
      chk("post_rd", 32'(rd_q[0]), 32'hA5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
